// File: rtl/wall_sequencer.sv
// Multi-wall obstacle controller: a shared READY/RUN/OVER game FSM
// launches, scrolls and scores N_WALLS walls. All outputs are registered.
module wall_sequencer #(
   parameter int N_WALLS  = 2,
   parameter int X_W      = 8,
   parameter int X_START  = 159,
   parameter int X_END    = 0,
   parameter int STEP_DIV = 4,
   parameter int GAP_W    = 4,
   parameter int SCORE_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic                   tick,
   input  logic [N_WALLS-1:0]     touched,
   input  logic [GAP_W-1:0]       spawn_gap,
   output logic                   start,
   output logic [N_WALLS-1:0]     move,
   output logic [N_WALLS*X_W-1:0] x_pos,
   output logic                   passed,
   output logic                   hit,
   output logic [SCORE_W-1:0]     score,
   output logic                   game_over
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int CNT_W = $clog2(N_WALLS + 1);
   localparam int SUM_W = SCORE_W + CNT_W;
   localparam logic [X_W-1:0]   XS       = X_W'(X_START);
   localparam logic [X_W-1:0]   XE       = X_W'(X_END);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {G_READY, G_RUN, G_OVER} game_e;
   typedef enum logic [1:0] {W_IDLE, W_MOVE, W_DONE} wall_e;

   game_e              game_q, game_d;
   wall_e              wall_q [N_WALLS];
   wall_e              wall_d [N_WALLS];
   logic [X_W-1:0]     x_q    [N_WALLS];
   logic [X_W-1:0]     x_d    [N_WALLS];
   logic [DIV_W-1:0]   div_q  [N_WALLS];
   logic [DIV_W-1:0]   div_d  [N_WALLS];
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gap_eff, gap_inc;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               passed_q, passed_d;
   logic               hit_q, hit_d;
   logic               touch_hit, launched;
   logic [CNT_W-1:0]   n_done;
   logic [SUM_W-1:0]   sum;

   always_comb begin
      move  = '0;
      x_pos = '0;
      for (int i = 0; i < N_WALLS; i++) begin
         move[i]              = (wall_q[i] == W_MOVE);
         x_pos[i*X_W +: X_W]  = x_q[i];
      end
   end

   assign start     = (game_q == G_READY);
   assign game_over = (game_q == G_OVER);
   assign passed    = passed_q;
   assign hit       = hit_q;
   assign score     = score_q;

   // Counter parks at expiry until an IDLE wall is available.
   assign gap_eff   = (spawn_gap == '0) ? GAP_W'(1) : spawn_gap;
   assign gap_inc   = (gap_q >= gap_eff) ? gap_q : gap_q + GAP_W'(1);
   assign touch_hit = |(touched & move);

   always_comb begin
      game_d   = game_q;
      gap_d    = gap_q;
      score_d  = score_q;
      passed_d = 1'b0;
      hit_d    = 1'b0;
      launched = 1'b0;
      n_done   = '0;
      sum      = '0;
      for (int i = 0; i < N_WALLS; i++) begin
         wall_d[i] = (wall_q[i] == W_DONE) ? W_IDLE : wall_q[i];
         x_d[i]    = x_q[i];
         div_d[i]  = div_q[i];
      end
      unique case (game_q)
         G_READY: begin
            if (go) begin
               game_d  = G_RUN;
               score_d = '0;
               gap_d   = gap_eff;
               for (int i = 0; i < N_WALLS; i++) wall_d[i] = W_IDLE;
            end
         end
         G_RUN: begin
            if (touch_hit) begin
               game_d = G_OVER;
               hit_d  = 1'b1;
            end else if (tick) begin
               for (int i = 0; i < N_WALLS; i++) begin
                  if (wall_q[i] == W_IDLE && !launched &&
                      gap_inc >= gap_eff) begin
                     wall_d[i] = W_MOVE;
                     x_d[i]    = XS;
                     div_d[i]  = '0;
                     launched  = 1'b1;
                  end else if (wall_q[i] == W_MOVE) begin
                     if (div_q[i] == DIV_LAST) begin
                        div_d[i] = '0;
                        if (x_q[i] - X_W'(1) == XE) begin
                           wall_d[i] = W_DONE;
                           x_d[i]    = XE;
                           n_done    = n_done + CNT_W'(1);
                        end else begin
                           x_d[i] = x_q[i] - X_W'(1);
                        end
                     end else begin
                        div_d[i] = div_q[i] + DIV_W'(1);
                     end
                  end
               end
               gap_d = launched ? '0 : gap_inc;
            end
         end
         G_OVER: begin
            if (!go) game_d = G_READY;
         end
         default: game_d = G_READY;
      endcase
      sum = SUM_W'(score_q) + SUM_W'(n_done);
      if (n_done != '0) begin
         passed_d = 1'b1;
         score_d  = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         game_q   <= G_READY;
         gap_q    <= '0;
         score_q  <= '0;
         passed_q <= 1'b0;
         hit_q    <= 1'b0;
         for (int i = 0; i < N_WALLS; i++) begin
            wall_q[i] <= W_IDLE;
            x_q[i]    <= XS;
            div_q[i]  <= '0;
         end
      end else begin
         game_q   <= game_d;
         gap_q    <= gap_d;
         score_q  <= score_d;
         passed_q <= passed_d;
         hit_q    <= hit_d;
         for (int i = 0; i < N_WALLS; i++) begin
            wall_q[i] <= wall_d[i];
            x_q[i]    <= x_d[i];
            div_q[i]  <= div_d[i];
         end
      end
   end

endmodule

// File: tb/tb_wall_sequencer.sv
// Scoreboard bench for wall_sequencer: directed games with expected
// output snapshots queued by stimulus and checked by a separate monitor.
module tb_wall_sequencer;

   logic        clk = 1'b0;
   logic        reset, go, tick;
   logic [1:0]  touched;
   logic [3:0]  spawn_gap;
   logic        start, passed, hit, game_over;
   logic [1:0]  move;
   logic [15:0] x_pos;
   logic [1:0]  score;
   logic        snap;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic       st, ov, ps, ht;
      bit         cmv;
      logic [1:0] mv;
      bit         cx;
      logic [7:0] x0, x1;
      logic [1:0] sc;
   } exp_t;

   exp_t q[$];

   wall_sequencer #(
      .N_WALLS(2), .X_W(8), .X_START(10), .X_END(0),
      .STEP_DIV(2), .GAP_W(4), .SCORE_W(2)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .tick(tick),
      .touched(touched), .spawn_gap(spawn_gap),
      .start(start), .move(move), .x_pos(x_pos),
      .passed(passed), .hit(hit), .score(score),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Monitor: any output event or requested snapshot consumes one entry.
   always @(negedge clk) begin
      if (snap || passed || hit) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got st=%b ov=%b ps=%b ht=%b mv=%b x=%h sc=%0d, required no event",
                     start, game_over, passed, hit, move, x_pos, score);
         end else begin
            exp_t e;
            bit   ok;
            e  = q.pop_front();
            ok = (start == e.st) && (game_over == e.ov) &&
                 (passed == e.ps) && (hit == e.ht) && (score == e.sc) &&
                 (!e.cmv || move == e.mv) &&
                 (!e.cx || x_pos == {e.x1, e.x0});
            if (!ok) begin
               errors++;
               $display("FAIL %s: got st=%b ov=%b ps=%b ht=%b mv=%b x=%h sc=%0d, required st=%b ov=%b ps=%b ht=%b mv=%b x=%h%h sc=%0d",
                        e.name, start, game_over, passed, hit, move, x_pos,
                        score, e.st, e.ov, e.ps, e.ht, e.mv, e.x1, e.x0, e.sc);
            end
         end
      end
   end

   task automatic clk_edge(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
      snap = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         clk_edge(1'b1);
         clk_edge(1'b0);
      end
   endtask

   task automatic expect_o(input string name, input logic st, input logic ov,
                           input logic ps, input logic ht, input bit cmv,
                           input logic [1:0] mv, input bit cx,
                           input logic [7:0] x0, input logic [7:0] x1,
                           input logic [1:0] sc);
      exp_t e;
      e.name = name; e.st = st; e.ov = ov; e.ps = ps; e.ht = ht;
      e.cmv = cmv; e.mv = mv; e.cx = cx; e.x0 = x0; e.x1 = x1; e.sc = sc;
      q.push_back(e);
      snap = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   initial begin
      int np;
      int pass_t[6];
      pass_t = '{21, 22, 42, 43, 63, 64};
      reset = 1'b1; go = 1'b0; tick = 1'b0; touched = '0;
      spawn_gap = 4'd3; snap = 1'b0;
      clk_edge(1'b0);
      clk_edge(1'b0);
      reset = 1'b0;
      expect_o("reset", 1, 0, 0, 0, 1, 2'b00, 1, 8'd10, 8'd10, 2'd0);

      // Game 1: gap 3
      go = 1'b1;
      clk_edge(1'b0);
      go = 1'b0;
      expect_o("run_entry", 0, 0, 0, 0, 1, 2'b00, 1, 8'd10, 8'd10, 2'd0);
      clk_edge(1'b1);
      expect_o("tick1_launch0", 0, 0, 0, 0, 1, 2'b01, 1, 8'd10, 8'd10, 2'd0);
      clk_edge(1'b0);
      tick_n(2);
      clk_edge(1'b1);
      expect_o("tick4_launch1", 0, 0, 0, 0, 1, 2'b11, 1, 8'd9, 8'd10, 2'd0);
      clk_edge(1'b0);
      tick_n(16);
      clk_edge(1'b1);
      expect_o("tick21_pass0", 0, 0, 1, 0, 1, 2'b10, 1, 8'd0, 8'd2, 2'd1);
      clk_edge(1'b0);
      clk_edge(1'b1);
      expect_o("tick22_relaunch0", 0, 0, 0, 0, 1, 2'b11, 1, 8'd10, 8'd1, 2'd1);
      clk_edge(1'b0);
      tick_n(1);
      clk_edge(1'b1);
      expect_o("tick24_pass1", 0, 0, 1, 0, 1, 2'b01, 1, 8'd9, 8'd0, 2'd2);
      clk_edge(1'b0);
      tick_n(7);
      expect_o("tick31_pos", 0, 0, 0, 0, 1, 2'b11, 1, 8'd6, 8'd7, 2'd2);
      touched = 2'b10; go = 1'b1;
      clk_edge(1'b0);
      touched = 2'b00;
      expect_o("touch1_hit", 0, 1, 0, 1, 1, 2'b11, 1, 8'd6, 8'd7, 2'd2);
      tick_n(10);
      expect_o("over_frozen", 0, 1, 0, 0, 1, 2'b11, 1, 8'd6, 8'd7, 2'd2);
      go = 1'b0;
      clk_edge(1'b0);
      expect_o("over_to_ready", 1, 0, 0, 0, 0, 2'b00, 0, 8'd0, 8'd0, 2'd2);
      touched = 2'b11;
      clk_edge(1'b1);
      touched = 2'b00;
      expect_o("ready_ignores", 1, 0, 0, 0, 0, 2'b00, 0, 8'd0, 8'd0, 2'd2);

      // Game 2: gap 0 acts as 1, deferred launch, touch beats pass
      spawn_gap = 4'd0;
      go = 1'b1;
      clk_edge(1'b0);
      go = 1'b0;
      expect_o("g2_entry", 0, 0, 0, 0, 1, 2'b00, 0, 8'd0, 8'd0, 2'd0);
      tick_n(1);
      clk_edge(1'b1);
      expect_o("g2_tick2", 0, 0, 0, 0, 1, 2'b11, 1, 8'd10, 8'd10, 2'd0);
      clk_edge(1'b0);
      clk_edge(1'b1);
      expect_o("g2_tick3_defer", 0, 0, 0, 0, 1, 2'b11, 1, 8'd9, 8'd10, 2'd0);
      clk_edge(1'b0);
      tick_n(17);
      clk_edge(1'b1);
      expect_o("g2_tick21_pass", 0, 0, 1, 0, 1, 2'b10, 1, 8'd0, 8'd1, 2'd1);
      clk_edge(1'b0);
      clk_edge(1'b1);
      expect_o("g2_tick22_both", 0, 0, 1, 0, 1, 2'b01, 1, 8'd10, 8'd0, 2'd2);
      clk_edge(1'b0);
      clk_edge(1'b1);
      expect_o("g2_tick23", 0, 0, 0, 0, 1, 2'b11, 1, 8'd10, 8'd10, 2'd2);
      clk_edge(1'b0);
      tick_n(18);
      expect_o("g2_tick41", 0, 0, 0, 0, 1, 2'b11, 1, 8'd1, 8'd1, 2'd2);
      touched = 2'b01;
      clk_edge(1'b1);
      touched = 2'b00;
      expect_o("touch_beats_pass", 0, 1, 0, 1, 1, 2'b11, 1, 8'd1, 8'd1, 2'd2);
      clk_edge(1'b0);
      expect_o("g2_ready", 1, 0, 0, 0, 0, 2'b00, 0, 8'd0, 8'd0, 2'd2);

      // Game 3: score saturation then reset mid-run
      spawn_gap = 4'd1;
      go = 1'b1;
      clk_edge(1'b0);
      go = 1'b0;
      expect_o("g3_entry", 0, 0, 0, 0, 1, 2'b00, 0, 8'd0, 8'd0, 2'd0);
      np = 0;
      for (int t = 1; t <= 66; t++) begin
         clk_edge(1'b1);
         if (np < 6 && t == pass_t[np]) begin
            np++;
            expect_o($sformatf("g3_pass%0d", np), 0, 0, 1, 0, 0, 2'b00, 0,
                     8'd0, 8'd0, (np > 3) ? 2'd3 : 2'(np));
         end
         clk_edge(1'b0);
      end
      reset = 1'b1;
      clk_edge(1'b0);
      reset = 1'b0;
      expect_o("reset_mid_run", 1, 0, 0, 0, 1, 2'b00, 1, 8'd10, 8'd10, 2'd0);
      clk_edge(1'b0);
      expect_o("idle_after_reset", 1, 0, 0, 0, 1, 2'b00, 1, 8'd10, 8'd10, 2'd0);
      clk_edge(1'b0);
      clk_edge(1'b0);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
